jtag_tap_sampled: RTL and testbench
===================================

Name: jtag_tap_sampled

Overview:
- Device-side JTAG TAP responder, i.e. the target end of the JTAG driving sequence the testbench issues: reset, bypass test, IDCODE read and config-register write.
- Runs entirely on the system clock.
- Oversamples TCK/TMS/TDI/TRSTn, detects TCK edges and advances a 16-state IEEE 1149.1 TAP FSM.
- Implements IDCODE, BYPASS and a 9-bit CONFREG data register whose value drives SoC test-mode/stim selection.

Parameters:
- IR_WIDTH, 5, instruction register width.
- IDCODE_VAL, 32'h249511C3, IDCODE value; bit0 must be 1.
- CONF_WIDTH, 9, CONFREG width.
- SYNC_STAGES, 2, synchronizer depth applied to all four JTAG inputs.

Ports:
- clk_i  in  1  system clock; must be ≥6x TCK frequency, each TCK phase ≥3 clk_i cycles.
- rst_n  in  1  asynchronous active-low reset.
- jtag_tck_i  in  1  JTAG clock, asynchronous.
- jtag_trst_ni  in  1  JTAG reset, active-low, asynchronous.
- jtag_tms_i  in  1  mode select.
- jtag_tdi_i  in  1  serial data in.
- jtag_tdo_o  out  1  serial data out.
- jtag_tdo_oe_o  out  1  TDO enable; high only in SHIFT_DR/SHIFT_IR.
- confreg_i  in  CONF_WIDTH  value captured in CAPTURE_DR for readback.
- confreg_o  out  CONF_WIDTH  last updated CONFREG value.
- confreg_upd_o  out  1  one clk_i pulse on UPDATE_DR with CONFREG selected.
- tap_state_o  out  4  current TAP state, for debug.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n is asynchronous and active-low. All flops use async rst_n.
- Reset values: tdo_o=0, tdo_oe_o=0, confreg_o=0, confreg_upd_o=0, state=TEST_LOGIC_RESET, IR=IDCODE.
- Synchronization: TCK, TMS, TDI and TRSTn pass through SYNC_STAGES flops with identical depth, so samples stay aligned.
- Edge detection: rise_ev = synced TCK 0→1; fall_ev = synced TCK 1→0. Each is a one-cycle pulse.
- Synced TRSTn low: state forced to TEST_LOGIC_RESET and IR=IDCODE. confreg_o is NOT altered; only rst_n clears it.
- On rise_ev the FSM transitions per the 1149.1 table using the synced TMS: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, and the same set for IR.
- Five consecutive TMS=1 rises from any state reach TLR.
- Actions on rise_ev are keyed on the current (pre-transition) state:
  - CAPTURE_IR: ir_sr <= 5'b00101.
  - SHIFT_IR: ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]}.
  - UPDATE_IR: IR <= ir_sr.
  - TLR: IR <= IDCODE.
  - CAPTURE_DR by IR:
    - IDCODE (5'b00001): dr_sr[31:0] <= IDCODE_VAL.
    - CONFREG (5'b00110): dr_sr[8:0] <= confreg_i.
    - BYPASS (5'b11111) and any unlisted opcode: dr_sr[0] <= 0.
  - SHIFT_DR: right-shift over the selected length (32, CONF_WIDTH or 1). TDI enters the MSB of the selected length.
  - UPDATE_DR with CONFREG: confreg_o <= dr_sr[8:0]; confreg_upd_o=1 for exactly one cycle. IDCODE/BYPASS updates have no effect.
- On fall_ev: in SH_DR/SH_IR, tdo_o <= LSB of the active shift register and tdo_oe_o=1; otherwise tdo_o=0, tdo_oe_o=0.
- Bit ordering: first TDO bit is the captured LSB. Shift latency is 1 TCK, so BYPASS echoes TDI delayed by one TCK.
- Simultaneous TRSTn low and rise_ev: TRSTn wins.
- rst_n during a shift: immediate abort, all outputs return to reset values.

Decomposition:
- Package jtag_tap_resp_pkg:
  - tap_state_e enum, 4 bits, TLR=4'h0.
  - Opcode constants IR_IDCODE, IR_BYPASS, IR_CONFREG.
  - IR capture pattern.
- Sub-module jtag_in_sync: parameterized synchronizer plus TCK rise/fall pulse generator.

Test Plan:
- rst_n low then high, TRSTn low 5 TCK, then TMS=1 x5 → tap_state_o=0; tdo_oe_o=0; confreg_o=9'h000.
- Right after reset, go to SHIFT_DR and shift 32 bits with TDI=0 → TDO LSB-first = 32'h249511C3.
- Load IR=5'b11111, shift 16 bits 16'hA5C3 in SHIFT_DR → TDO = 0 then the TDI stream delayed one TCK; confreg_o unchanged.
- Load IR=5'b00110, shift 9'b0_0000_001_0 and run UPDATE_DR → confreg_o=9'h002, confreg_upd_o pulses exactly once; then with confreg_i=9'h002, CAPTURE/SHIFT → TDO reads 9'h002.
- Mid SHIFT_DR of CONFREG, drop TRSTn → state=TLR, IR=IDCODE, confreg_o holds its prior value, no upd pulse.
- Assert rst_n mid SHIFT_IR with TCK running → all outputs at reset values within one clk_i; after release, IDCODE reads correctly.

Source files
------------

// File: rtl/jtag_tap_resp_pkg.sv
// Shared types and constants for the sampled JTAG TAP responder.
package jtag_tap_resp_pkg;

    // IEEE 1149.1 TAP controller states; TLR must encode as zero.
    typedef enum logic [3:0] {
        TAP_TLR    = 4'h0,
        TAP_RTI    = 4'h1,
        TAP_SEL_DR = 4'h2,
        TAP_CAP_DR = 4'h3,
        TAP_SH_DR  = 4'h4,
        TAP_EX1_DR = 4'h5,
        TAP_PA_DR  = 4'h6,
        TAP_EX2_DR = 4'h7,
        TAP_UPD_DR = 4'h8,
        TAP_SEL_IR = 4'h9,
        TAP_CAP_IR = 4'hA,
        TAP_SH_IR  = 4'hB,
        TAP_EX1_IR = 4'hC,
        TAP_PA_IR  = 4'hD,
        TAP_EX2_IR = 4'hE,
        TAP_UPD_IR = 4'hF
    } tap_state_e;

    // Data register currently routed between TDI and TDO.
    typedef enum logic [1:0] {
        SEL_BYPASS  = 2'd0,
        SEL_IDCODE  = 2'd1,
        SEL_CONFREG = 2'd2
    } dr_sel_e;

    localparam int unsigned OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] IR_IDCODE  = 5'b00001;
    localparam logic [OPCODE_W-1:0] IR_BYPASS  = 5'b11111;
    localparam logic [OPCODE_W-1:0] IR_CONFREG = 5'b00110;

    // Pattern loaded into the IR shift register in CAPTURE_IR (LSBs 01 as 1149.1 requires).
    localparam logic [OPCODE_W-1:0] IR_CAPTURE = 5'b00101;

    // Longest data register (IDCODE); all DR paths share one shift register of this width.
    localparam int unsigned DR_MAX_W = 32;

endpackage

// File: rtl/jtag_in_sync.sv
// Synchronizes the four asynchronous JTAG pins into clk_i and derives
// single-cycle TCK rise/fall pulses from the synchronized clock.
module jtag_in_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic tck_i,
    input  logic trst_ni,
    input  logic tms_i,
    input  logic tdi_i,
    output logic trst_no,
    output logic tms_o,
    output logic tdi_o,
    output logic rise_o,
    output logic fall_o
);

    // Bit layout of one synchronizer stage: {tdi, tms, trst_n, tck}.
    // Reset holds TRSTn asserted and TMS high so the TAP stays in TLR
    // until real pin values have propagated through the chain.
    localparam logic [3:0] SYNC_RST = 4'b0100;

    logic [STAGES-1:0][3:0] sync_q;
    logic                   tck_prev_q;
    logic                   tck_s;

    // All four pins share one chain so TMS/TDI stay aligned with the TCK edge they belong to.
    always_ff @(posedge clk_i or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples the
        // previous stage's old value; blocking here would collapse the chain into one flop.
        if (!rst_n) begin
            sync_q <= {STAGES{SYNC_RST}};
        end else begin
            sync_q[0] <= {tdi_i, tms_i, trst_ni, tck_i};
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign tck_s   = sync_q[STAGES-1][0];
    assign trst_no = sync_q[STAGES-1][1];
    assign tms_o   = sync_q[STAGES-1][2];
    assign tdi_o   = sync_q[STAGES-1][3];

    // One-cycle history of synchronized TCK for edge detection.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tck_prev_q <= 1'b0;
        end else begin
            tck_prev_q <= tck_s;
        end
    end

    assign rise_o = tck_s & ~tck_prev_q;
    assign fall_o = ~tck_s & tck_prev_q;

endmodule

// File: rtl/jtag_tap_sampled.sv
// Device-side JTAG TAP clocked entirely by clk_i: TCK is oversampled and the
// 16-state TAP FSM advances on detected TCK edges. Provides IDCODE, BYPASS and
// a CONF_WIDTH-bit configuration register that drives SoC test-mode selection.
module jtag_tap_sampled
    import jtag_tap_resp_pkg::*;
#(
    parameter int unsigned IR_WIDTH    = 5,
    parameter logic [31:0] IDCODE_VAL  = 32'h249511C3,
    parameter int unsigned CONF_WIDTH  = 9,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  jtag_tck_i,
    input  logic                  jtag_trst_ni,
    input  logic                  jtag_tms_i,
    input  logic                  jtag_tdi_i,
    output logic                  jtag_tdo_o,
    output logic                  jtag_tdo_oe_o,
    input  logic [CONF_WIDTH-1:0] confreg_i,
    output logic [CONF_WIDTH-1:0] confreg_o,
    output logic                  confreg_upd_o,
    output logic [3:0]            tap_state_o
);

    localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(IR_IDCODE);
    localparam logic [IR_WIDTH-1:0] OP_CONFREG = IR_WIDTH'(IR_CONFREG);
    localparam logic [IR_WIDTH-1:0] OP_CAPTURE = IR_WIDTH'(IR_CAPTURE);

    // ------------------------------------------------------------------
    // Synchronized pins and TCK edge pulses
    // ------------------------------------------------------------------
    logic trst_s;
    logic tms_s;
    logic tdi_s;
    logic rise_ev;
    logic fall_ev;

    jtag_in_sync #(
        .STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .tck_i   (jtag_tck_i),
        .trst_ni (jtag_trst_ni),
        .tms_i   (jtag_tms_i),
        .tdi_i   (jtag_tdi_i),
        .trst_no (trst_s),
        .tms_o   (tms_s),
        .tdi_o   (tdi_s),
        .rise_o  (rise_ev),
        .fall_o  (fall_ev)
    );

    // ------------------------------------------------------------------
    // TAP FSM
    // ------------------------------------------------------------------
    tap_state_e state_q, state_d;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: TRSTn overrides everything, otherwise step the 1149.1 table on a TCK rise.
    always_comb begin
        // NOTE: the default assignment up front keeps this block purely combinational;
        // any path that skipped an assignment would otherwise infer a latch.
        state_d = state_q;
        if (!trst_s) begin
            state_d = TAP_TLR;
        end else if (rise_ev) begin
            unique case (state_q)
                TAP_TLR:    state_d = tms_s ? TAP_TLR    : TAP_RTI;
                TAP_RTI:    state_d = tms_s ? TAP_SEL_DR : TAP_RTI;
                TAP_SEL_DR: state_d = tms_s ? TAP_SEL_IR : TAP_CAP_DR;
                TAP_CAP_DR: state_d = tms_s ? TAP_EX1_DR : TAP_SH_DR;
                TAP_SH_DR:  state_d = tms_s ? TAP_EX1_DR : TAP_SH_DR;
                TAP_EX1_DR: state_d = tms_s ? TAP_UPD_DR : TAP_PA_DR;
                TAP_PA_DR:  state_d = tms_s ? TAP_EX2_DR : TAP_PA_DR;
                TAP_EX2_DR: state_d = tms_s ? TAP_UPD_DR : TAP_SH_DR;
                TAP_UPD_DR: state_d = tms_s ? TAP_SEL_DR : TAP_RTI;
                TAP_SEL_IR: state_d = tms_s ? TAP_TLR    : TAP_CAP_IR;
                TAP_CAP_IR: state_d = tms_s ? TAP_EX1_IR : TAP_SH_IR;
                TAP_SH_IR:  state_d = tms_s ? TAP_EX1_IR : TAP_SH_IR;
                TAP_EX1_IR: state_d = tms_s ? TAP_UPD_IR : TAP_PA_IR;
                TAP_PA_IR:  state_d = tms_s ? TAP_EX2_IR : TAP_PA_IR;
                TAP_EX2_IR: state_d = tms_s ? TAP_UPD_IR : TAP_SH_IR;
                TAP_UPD_IR: state_d = tms_s ? TAP_SEL_DR : TAP_RTI;
                default:    state_d = TAP_TLR;
            endcase
        end
    end

    // Per-state actions on a TCK rise, keyed on the pre-transition state.
    logic act_tlr, act_cap_ir, act_sh_ir, act_upd_ir;
    logic act_cap_dr, act_sh_dr, act_upd_dr;
    logic rise_ok;

    assign rise_ok = rise_ev & trst_s;

    // Action decode.
    always_comb begin
        act_tlr    = 1'b0;
        act_cap_ir = 1'b0;
        act_sh_ir  = 1'b0;
        act_upd_ir = 1'b0;
        act_cap_dr = 1'b0;
        act_sh_dr  = 1'b0;
        act_upd_dr = 1'b0;
        if (rise_ok) begin
            unique case (state_q)
                TAP_TLR:    act_tlr    = 1'b1;
                TAP_CAP_IR: act_cap_ir = 1'b1;
                TAP_SH_IR:  act_sh_ir  = 1'b1;
                TAP_UPD_IR: act_upd_ir = 1'b1;
                TAP_CAP_DR: act_cap_dr = 1'b1;
                TAP_SH_DR:  act_sh_dr  = 1'b1;
                TAP_UPD_DR: act_upd_dr = 1'b1;
                default: ;
            endcase
        end
    end

    assign tap_state_o = state_q;

    // ------------------------------------------------------------------
    // Instruction register
    // ------------------------------------------------------------------
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_sr_q;

    // Capture/shift the IR scan chain and latch the active instruction.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ir_q    <= OP_IDCODE;
            ir_sr_q <= '0;
        end else if (!trst_s) begin
            ir_q <= OP_IDCODE;
        end else begin
            if (act_cap_ir) ir_sr_q <= OP_CAPTURE;
            if (act_sh_ir)  ir_sr_q <= {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
            if (act_upd_ir) ir_q    <= ir_sr_q;
            if (act_tlr)    ir_q    <= OP_IDCODE;
        end
    end

    // Unlisted opcodes fall back to the 1-bit bypass path.
    dr_sel_e dr_sel;
    always_comb begin
        if (ir_q == OP_IDCODE) begin
            dr_sel = SEL_IDCODE;
        end else if (ir_q == OP_CONFREG) begin
            dr_sel = SEL_CONFREG;
        end else begin
            dr_sel = SEL_BYPASS;
        end
    end

    // ------------------------------------------------------------------
    // Data register path
    // ------------------------------------------------------------------
    logic [DR_MAX_W-1:0] dr_sr_q;
    logic [DR_MAX_W-1:0] dr_shift;

    // Right shift over the selected length; TDI enters that length's MSB.
    always_comb begin
        dr_shift = dr_sr_q;
        unique case (dr_sel)
            SEL_IDCODE:  dr_shift = {tdi_s, dr_sr_q[DR_MAX_W-1:1]};
            SEL_CONFREG: dr_shift[CONF_WIDTH-1:0] = {tdi_s, dr_sr_q[CONF_WIDTH-1:1]};
            default:     dr_shift[0] = tdi_s;
        endcase
    end

    // Capture and shift the DR scan chain.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            dr_sr_q <= '0;
        end else if (act_cap_dr) begin
            unique case (dr_sel)
                SEL_IDCODE:  dr_sr_q                   <= IDCODE_VAL;
                SEL_CONFREG: dr_sr_q[CONF_WIDTH-1:0]   <= confreg_i;
                default:     dr_sr_q[0]                <= 1'b0;
            endcase
        end else if (act_sh_dr) begin
            dr_sr_q <= dr_shift;
        end
    end

    // CONFREG update: only rst_n clears the held value, TRSTn merely suppresses the pulse.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            confreg_o     <= '0;
            confreg_upd_o <= 1'b0;
        end else if (act_upd_dr && dr_sel == SEL_CONFREG) begin
            confreg_o     <= dr_sr_q[CONF_WIDTH-1:0];
            confreg_upd_o <= 1'b1;
        end else begin
            confreg_upd_o <= 1'b0;
        end
    end

    // TDO launches on the TCK fall so the host samples a stable bit on the next rise.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            jtag_tdo_o    <= 1'b0;
            jtag_tdo_oe_o <= 1'b0;
        end else if (!trst_s) begin
            jtag_tdo_o    <= 1'b0;
            jtag_tdo_oe_o <= 1'b0;
        end else if (fall_ev) begin
            if (state_q == TAP_SH_DR) begin
                jtag_tdo_o    <= dr_sr_q[0];
                jtag_tdo_oe_o <= 1'b1;
            end else if (state_q == TAP_SH_IR) begin
                jtag_tdo_o    <= ir_sr_q[0];
                jtag_tdo_oe_o <= 1'b1;
            end else begin
                jtag_tdo_o    <= 1'b0;
                jtag_tdo_oe_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Randomized bench for jtag_tap_sampled: a host-side JTAG driver pushes the
// expected TDO stream into a scoreboard queue and a monitor pops and compares
// each bit while TDO is enabled. Expectations come from a register-level model
// (captured value followed by the TDI stream, LSB first).
module tb_jtag_tap_sampled;

    localparam logic [31:0] IDC        = 32'h249511C3;
    localparam logic [4:0]  OP_IDCODE  = 5'b00001;
    localparam logic [4:0]  OP_BYPASS  = 5'b11111;
    localparam logic [4:0]  OP_CONFREG = 5'b00110;
    localparam logic [4:0]  IR_CAP     = 5'b00101;
    localparam int          P          = 5;     // clk_i cycles per TCK phase

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       tck = 1'b0;
    logic       trst_n = 1'b0;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic [8:0] confreg_i = '0;
    logic       tdo, tdo_oe, confreg_upd;
    logic [8:0] confreg_o;
    logic [3:0] tap_state;

    jtag_tap_sampled dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .jtag_tck_i    (tck),
        .jtag_trst_ni  (trst_n),
        .jtag_tms_i    (tms),
        .jtag_tdi_i    (tdi),
        .jtag_tdo_o    (tdo),
        .jtag_tdo_oe_o (tdo_oe),
        .confreg_i     (confreg_i),
        .confreg_o     (confreg_o),
        .confreg_upd_o (confreg_upd),
        .tap_state_o   (tap_state)
    );

    always #5 clk_i = ~clk_i;

    int         checks = 0;
    int         failures = 0;
    bit         exp_q[$];
    int         upd_seen = 0;
    int         upd_exp = 0;
    logic [4:0] ir_m = OP_IDCODE;
    logic [8:0] conf_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each host TCK rise with TDO enabled consumes one expected bit.
    always @(posedge tck) begin
        if (tdo_oe === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tdo_unexpected actual=%0b expected=no_output at %0t", tdo, $time);
            end else begin
                bit e;
                e = exp_q.pop_front();
                check("tdo_bit", {31'd0, tdo}, {31'd0, e});
            end
        end
    end

    // Count clk_i cycles with the update strobe high.
    always @(negedge clk_i) begin
        if (confreg_upd === 1'b1) upd_seen++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tck_cycle(input logic t, input logic d);
        tms = t;
        tdi = d;
        repeat (P) @(negedge clk_i);
        tck = 1'b1;
        repeat (P) @(negedge clk_i);
        tck = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(negedge clk_i);
    endtask

    // Bit k of the serial stream the DR holds: captured bits first, then TDI.
    function automatic bit sbit(input logic [31:0] cap, input int cap_len,
                                input logic [31:0] tdi_bits, input int k);
        if (k < cap_len) return cap[k];
        if (k - cap_len < 32) return tdi_bits[k - cap_len];
        return 1'b0;
    endfunction

    task automatic ir_scan(input logic [4:0] op);
        for (int i = 0; i < 5; i++) exp_q.push_back(IR_CAP[i]);
        tck_cycle(1, 0);  // SEL_DR
        tck_cycle(1, 0);  // SEL_IR
        tck_cycle(0, 0);  // CAP_IR
        tck_cycle(0, 0);  // SH_IR
        for (int i = 0; i < 5; i++) tck_cycle(i == 4, op[i]);
        tck_cycle(1, 0);  // UPD_IR
        tck_cycle(0, 0);  // RTI
        ir_m = op;
    endtask

    // Full DR scan from RTI back to RTI, always passing through UPDATE_DR.
    task automatic dr_scan(input int n, input logic [31:0] tdi_bits);
        logic [31:0] cap;
        int          cap_len;
        if (ir_m == OP_IDCODE) begin
            cap = IDC; cap_len = 32;
        end else if (ir_m == OP_CONFREG) begin
            cap = {23'd0, confreg_i}; cap_len = 9;
        end else begin
            cap = '0; cap_len = 1;
        end
        for (int i = 0; i < n; i++) exp_q.push_back(sbit(cap, cap_len, tdi_bits, i));
        tck_cycle(1, 0);  // SEL_DR
        tck_cycle(0, 0);  // CAP_DR
        tck_cycle(0, 0);  // SH_DR
        for (int i = 0; i < n; i++) tck_cycle(i == n - 1, tdi_bits[i]);
        tck_cycle(1, 0);  // UPD_DR
        tck_cycle(0, 0);  // RTI
        if (ir_m == OP_CONFREG) begin
            for (int j = 0; j < 9; j++) conf_m[j] = sbit(cap, cap_len, tdi_bits, n + j);
            upd_exp++;
        end
        settle();
        check("confreg_o", {23'd0, confreg_o}, {23'd0, conf_m});
        check("upd_count", upd_seen, upd_exp);
    endtask

    initial begin
        logic [8:0] saved_conf;
        logic [4:0] op;
        int         kind;

        // Reset values
        repeat (4) @(negedge clk_i);
        check("rst_state", {28'd0, tap_state}, 32'd0);
        check("rst_tdo", {31'd0, tdo}, 32'd0);
        check("rst_tdo_oe", {31'd0, tdo_oe}, 32'd0);
        check("rst_confreg", {23'd0, confreg_o}, 32'd0);
        check("rst_upd", {31'd0, confreg_upd}, 32'd0);
        rst_n = 1'b1;
        repeat (5) tck_cycle(1, 0);
        trst_n = 1'b1;
        repeat (5) tck_cycle(1, 0);
        settle();
        check("tlr_state", {28'd0, tap_state}, 32'd0);
        check("tlr_tdo_oe", {31'd0, tdo_oe}, 32'd0);
        check("tlr_confreg", {23'd0, confreg_o}, 32'd0);
        tck_cycle(0, 0);  // RTI

        // IDCODE is the default instruction
        dr_scan(32, 32'd0);

        // BYPASS echoes TDI one TCK late
        ir_scan(OP_BYPASS);
        dr_scan(16, 32'h0000_A5C3);

        // CONFREG write then readback
        ir_scan(OP_CONFREG);
        confreg_i = 9'h000;
        dr_scan(9, 32'h002);
        check("confreg_written", {23'd0, confreg_o}, 32'h002);
        confreg_i = 9'h002;
        dr_scan(9, 32'h002);

        // Randomized mix of scans
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                ir_scan(OP_CONFREG);
                confreg_i = 9'($urandom);
                dr_scan($urandom_range(9, 24), $urandom);
            end else if (kind == 1) begin
                op = 5'($urandom);
                if (op == OP_IDCODE || op == OP_CONFREG) op = OP_BYPASS;
                ir_scan(op);
                dr_scan($urandom_range(1, 32), $urandom);
            end else begin
                ir_scan(OP_IDCODE);
                dr_scan($urandom_range(1, 32), $urandom);
            end
        end

        // TRSTn mid CONFREG shift: TLR, IR back to IDCODE, confreg held, no update pulse
        ir_scan(OP_CONFREG);
        confreg_i = 9'($urandom);
        saved_conf = conf_m;
        for (int i = 0; i < 5; i++) exp_q.push_back(confreg_i[i]);
        tck_cycle(1, 0);
        tck_cycle(0, 0);
        tck_cycle(0, 0);
        for (int i = 0; i < 5; i++) tck_cycle(0, 1'($urandom));
        trst_n = 1'b0;
        repeat (5) tck_cycle(1, 0);
        settle();
        check("trst_state", {28'd0, tap_state}, 32'd0);
        check("trst_tdo_oe", {31'd0, tdo_oe}, 32'd0);
        check("trst_confreg", {23'd0, confreg_o}, {23'd0, saved_conf});
        check("trst_upd_count", upd_seen, upd_exp);
        trst_n = 1'b1;
        ir_m = OP_IDCODE;
        settle();
        tck_cycle(0, 0);  // RTI
        dr_scan(32, $urandom);

        // rst_n mid SHIFT_IR with TCK running
        ir_scan(OP_CONFREG);
        confreg_i = 9'h000;
        dr_scan(9, 32'h1A5);
        for (int i = 0; i < 3; i++) exp_q.push_back(IR_CAP[i]);
        tck_cycle(1, 0);
        tck_cycle(1, 0);
        tck_cycle(0, 0);
        tck_cycle(0, 0);
        for (int i = 0; i < 3; i++) tck_cycle(0, 1'($urandom));
        settle();
        check("shir_tdo_oe", {31'd0, tdo_oe}, 32'd1);
        check("shir_tdo", {31'd0, tdo}, {31'd0, IR_CAP[3]});
        @(negedge clk_i);
        rst_n = 1'b0;
        #1;
        check("abort_state", {28'd0, tap_state}, 32'd0);
        check("abort_tdo", {31'd0, tdo}, 32'd0);
        check("abort_tdo_oe", {31'd0, tdo_oe}, 32'd0);
        check("abort_confreg", {23'd0, confreg_o}, 32'd0);
        check("abort_upd", {31'd0, confreg_upd}, 32'd0);
        exp_q.delete();
        repeat (3) tck_cycle(1, 0);
        rst_n = 1'b1;
        conf_m = '0;
        ir_m = OP_IDCODE;
        repeat (5) tck_cycle(1, 0);
        tck_cycle(0, 0);  // RTI
        dr_scan(32, $urandom);

        settle();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
